pipe_hazard_ctrl: RTL

- Central pipeline sequencer that drives the IF/ID register's write-hold and flush controls, the PC hold and the ID/EX bubble insert.
- Resolves three events in fixed priority: memory-stall freeze, load-use stall (multi-cycle, parameterised) and taken-branch/jump flush, with deferral of flushes that land during a freeze.
- Sits beside the ID stage; all control outputs are combinational from registered state plus current-cycle inputs, so the pipeline registers act on the next posedge.

---
 rtl/pipe_hazard_ctrl_if.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the ID stage and the hazard sequencer.
// slave = sequencer side, master = pipeline side.
interface pipe_hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] id_rs_i;
   logic [REG_W-1:0] id_rt_i;
   logic             ex_memread_i;
   logic [REG_W-1:0] ex_rd_i;
   logic             branch_taken_i;
   logic             jump_i;
   logic             mem_stall_i;
   logic             pc_hold_o;
   logic             ifid_hold_o;
   logic             ifid_flush_o;
   logic             idex_bubble_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   modport slave (
      input  id_rs_i, id_rt_i, ex_memread_i, ex_rd_i, branch_taken_i, jump_i, mem_stall_i,
      output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, stall_cnt_o, flush_cnt_o
   );
   modport master (
      output id_rs_i, id_rt_i, ex_memread_i, ex_rd_i, branch_taken_i, jump_i, mem_stall_i,
      input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: memory freeze > load-use stall > branch/jump flush.
// PIPE_HAZARD_CTRL_PERF_EN enables the stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int REG_W           = 5,
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   pipe_hazard_ctrl_if.slave     hz_if
);
   typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

   state_t     state, state_nx, ret_state, ret_nx, eff;
   logic [3:0] lu_cnt, lu_nx;
   logic       flush_pend, pend_nx;
   logic       hz, fr;
   logic       pc_hold, ifid_hold, ifid_flush, idex_bubble;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= RUN;
         ret_state  <= RUN;
         lu_cnt     <= '0;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nx;
         ret_state  <= ret_nx;
         lu_cnt     <= lu_nx;
         flush_pend <= pend_nx;
      end
   end

   always_comb begin
      hz = hz_if.ex_memread_i && (hz_if.ex_rd_i != '0) &&
           ((hz_if.ex_rd_i == hz_if.id_rs_i) || (hz_if.ex_rd_i == hz_if.id_rt_i));
      fr = hz_if.branch_taken_i || hz_if.jump_i || flush_pend;
      // MEM_WAIT replays whichever state the freeze interrupted
      eff         = (state == MEM_WAIT) ? ret_state : state;
      state_nx    = state;
      ret_nx      = ret_state;
      lu_nx       = lu_cnt;
      pend_nx     = flush_pend;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (hz_if.mem_stall_i) begin
         pc_hold   = 1'b1;
         ifid_hold = 1'b1;
         state_nx  = MEM_WAIT;
         ret_nx    = eff;
         if (hz_if.branch_taken_i || hz_if.jump_i) pend_nx = 1'b1;
      end else if (eff == LU_STALL) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
         lu_nx       = lu_cnt - 4'd1;
         state_nx    = (lu_cnt <= 4'd1) ? RUN : LU_STALL;
      end else if (hz) begin
         pc_hold     = 1'b1;
         ifid_hold   = 1'b1;
         idex_bubble = 1'b1;
         if (LU_STALL_CYCLES > 1) begin
            lu_nx    = 4'(LU_STALL_CYCLES - 1);
            state_nx = LU_STALL;
         end else begin
            state_nx = RUN;
         end
      end else if (fr) begin
         ifid_flush = 1'b1;
         pend_nx    = 1'b0;
         state_nx   = RUN;
      end else begin
         state_nx = RUN;
      end
   end

   assign hz_if.pc_hold_o     = rst_i & pc_hold;
   assign hz_if.ifid_hold_o   = rst_i & ifid_hold;
   assign hz_if.ifid_flush_o  = rst_i & ifid_flush;
   assign hz_if.idex_bubble_o = rst_i & idex_bubble;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // saturating: a pegged counter means "at least this many"
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (pc_hold && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
         if (ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign hz_if.stall_cnt_o = stall_cnt;
   assign hz_if.flush_cnt_o = flush_cnt;
`else
   assign hz_if.stall_cnt_o = '0;
   assign hz_if.flush_cnt_o = '0;
`endif
endmodule
